deframer: RTL and testbench

- Receive-side counterpart of the OSC/UDP transmit framer.
- AXI4-Lite master that polls the Ethernet-Lite MAC RX ping buffer (13-bit register space) and reads a received frame word by word.
- Validates the Ethernet/IPv4/UDP header fields and extracts eight 16-bit payload values.
- Delivers the values as one 128-bit AXI-Stream beat, then releases the RX buffer back to the MAC.

---
 rtl/deframer.sv | 109 ++++++++++
 tb/tb_deframer.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/deframer.sv
// deframer: AXI4-Lite poller of the Ethernet-Lite RX ping buffer that validates an
// IPv4/UDP frame and emits its eight 16-bit payload values as one AXI-Stream beat.
module deframer #(
    parameter logic [12:0] RX_BASE  = 13'h1000,
    parameter logic [12:0] RX_CTRL  = 13'h17FC,
    parameter logic [15:0] UDP_PORT = 16'h07C5
) (
    input  logic         aclk,
    input  logic         aresetn,
    output logic [127:0] m_axis_tdata,
    output logic         m_axis_tvalid,
    input  logic         m_axis_tready,
    output logic [12:0]  m_axi_araddr,
    output logic         m_axi_arvalid,
    input  logic         m_axi_arready,
    input  logic [31:0]  m_axi_rdata,
    input  logic [1:0]   m_axi_rresp,
    input  logic         m_axi_rvalid,
    output logic         m_axi_rready,
    output logic [12:0]  m_axi_awaddr,
    output logic         m_axi_awvalid,
    input  logic         m_axi_awready,
    output logic [31:0]  m_axi_wdata,
    output logic [3:0]   m_axi_wstrb,
    output logic         m_axi_wvalid,
    input  logic         m_axi_wready,
    input  logic [1:0]   m_axi_bresp,
    input  logic         m_axi_bvalid,
    output logic         m_axi_bready,
    output logic [15:0]  frame_count,
    output logic [15:0]  drop_count
);
    typedef enum logic [2:0] {S_POLL, S_POLL_R, S_READ, S_READ_R, S_OUT, S_REL, S_WAIT_B} state_t;
    state_t       r_state, w_next;
    logic [4:0]   r_k, w_off;
    logic         r_bad, r_arvalid, r_awvalid, r_wvalid;
    logic [127:0] r_tdata;
    logic [15:0]  r_frames, r_drops;
    logic         w_rhs, w_last, w_fail, w_aw_done, w_w_done, w_unused;

    assign w_rhs     = m_axi_rvalid && m_axi_rready;
    assign w_last    = r_k == 5'd24;
    assign w_off     = r_k - 5'd17;
    // Header fields are little-endian packed: byte 0 of the frame sits in rdata[7:0].
    assign w_fail    = (m_axi_rresp != 2'b00)
                    || (r_k == 5'd3 && m_axi_rdata[15:0] != 16'h0008)
                    || (r_k == 5'd5 && m_axi_rdata[31:24] != 8'h11)
                    || (r_k == 5'd9 && {m_axi_rdata[7:0], m_axi_rdata[15:8]} != UDP_PORT);
    assign w_aw_done = !r_awvalid || m_axi_awready;
    assign w_w_done  = !r_wvalid || m_axi_wready;
    assign w_unused  = ^{m_axi_bresp, m_axi_rdata[23:16]};

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_POLL:   w_next = (r_arvalid && m_axi_arready) ? S_POLL_R : S_POLL;
            S_POLL_R: w_next = !w_rhs ? S_POLL_R : m_axi_rdata[0] ? S_READ : S_POLL;
            S_READ:   w_next = (r_arvalid && m_axi_arready) ? S_READ_R : S_READ;
            S_READ_R: w_next = !w_rhs ? S_READ_R : !w_last ? S_READ : (r_bad || w_fail) ? S_REL : S_OUT;
            S_OUT:    w_next = m_axis_tready ? S_REL : S_OUT;
            S_REL:    w_next = (w_aw_done && w_w_done) ? S_WAIT_B : S_REL;
            S_WAIT_B: w_next = m_axi_bvalid ? S_POLL : S_WAIT_B;
            default:  w_next = S_POLL;
        endcase
    end

    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            r_state   <= S_POLL;
            r_k       <= '0;
            r_bad     <= 1'b0;
            r_arvalid <= 1'b0;
            r_awvalid <= 1'b0;
            r_wvalid  <= 1'b0;
            r_tdata   <= '0;
            r_frames  <= '0;
            r_drops   <= '0;
        end else begin
            r_state   <= w_next;
            // Every entry into an address state (including a repoll) issues a fresh read.
            r_arvalid <= (w_next == S_POLL) || (w_next == S_READ);
            r_awvalid <= (r_state != S_REL && w_next == S_REL) || (r_awvalid && !m_axi_awready);
            r_wvalid  <= (r_state != S_REL && w_next == S_REL) || (r_wvalid && !m_axi_wready);
            if (r_state == S_POLL_R) r_k <= '0;
            if (r_state == S_READ_R && w_rhs) begin
                r_k   <= r_k + 5'd1;
                r_bad <= r_bad || w_fail;
                if (r_k >= 5'd17) r_tdata[{w_off[2:0], 4'h0} +: 16] <= m_axi_rdata[15:0];
                if (w_last && (r_bad || w_fail)) r_drops <= r_drops + 16'd1;
            end
            if (r_state == S_OUT && m_axis_tready) r_frames <= r_frames + 16'd1;
            if (r_state == S_WAIT_B && m_axi_bvalid) r_bad <= 1'b0;
        end
    end

    assign m_axis_tdata  = r_tdata;
    assign m_axis_tvalid = r_state == S_OUT;
    assign m_axi_arvalid = r_arvalid;
    assign m_axi_araddr  = !r_arvalid ? 13'd0 : (r_state == S_READ) ? RX_BASE + {6'd0, r_k, 2'b00} : RX_CTRL;
    assign m_axi_rready  = (r_state == S_POLL_R) || (r_state == S_READ_R);
    assign m_axi_awvalid = r_awvalid;
    assign m_axi_awaddr  = r_awvalid ? RX_CTRL : 13'd0;
    assign m_axi_wvalid  = r_wvalid;
    assign m_axi_wdata   = 32'd0;
    assign m_axi_wstrb   = 4'hF;
    assign m_axi_bready  = r_state == S_WAIT_B;
    assign frame_count   = r_frames;
    assign drop_count    = r_drops;
endmodule

// File: tb/tb_deframer.sv
// tb_deframer: scoreboard bench; an AXI4-Lite slave model plays the MAC RX buffer
// and expected stream beats are queued when each frame is loaded.
module tb_deframer;
    logic         aclk = 1'b0, aresetn = 1'b0;
    logic [127:0] m_axis_tdata;
    logic         m_axis_tvalid, m_axis_tready;
    logic [12:0]  m_axi_araddr, m_axi_awaddr;
    logic         m_axi_arvalid, m_axi_arready, m_axi_rvalid, m_axi_rready;
    logic [31:0]  m_axi_rdata, m_axi_wdata;
    logic [1:0]   m_axi_rresp, m_axi_bresp;
    logic         m_axi_awvalid, m_axi_awready, m_axi_wvalid, m_axi_wready, m_axi_bvalid, m_axi_bready;
    logic [3:0]   m_axi_wstrb;
    logic [15:0]  frame_count, drop_count;

    always #5 aclk = ~aclk;

    deframer dut (
        .aclk(aclk), .aresetn(aresetn),
        .m_axis_tdata(m_axis_tdata), .m_axis_tvalid(m_axis_tvalid), .m_axis_tready(m_axis_tready),
        .m_axi_araddr(m_axi_araddr), .m_axi_arvalid(m_axi_arvalid), .m_axi_arready(m_axi_arready),
        .m_axi_rdata(m_axi_rdata), .m_axi_rresp(m_axi_rresp), .m_axi_rvalid(m_axi_rvalid), .m_axi_rready(m_axi_rready),
        .m_axi_awaddr(m_axi_awaddr), .m_axi_awvalid(m_axi_awvalid), .m_axi_awready(m_axi_awready),
        .m_axi_wdata(m_axi_wdata), .m_axi_wstrb(m_axi_wstrb), .m_axi_wvalid(m_axi_wvalid), .m_axi_wready(m_axi_wready),
        .m_axi_bresp(m_axi_bresp), .m_axi_bvalid(m_axi_bvalid), .m_axi_bready(m_axi_bready),
        .frame_count(frame_count), .drop_count(drop_count)
    );

    logic [31:0]  mem [0:24];
    logic [127:0] sb_q [$];
    logic         ctrl_val = 1'b0;
    logic [12:0]  last_waddr = '0;
    logic [31:0]  last_wdata = '1;
    int n_chk = 0, n_err = 0;
    int polls_left = 0, err_k = -1, aw_delay = 0, w_delay = 0;
    int ctrl_reads = 0, data_reads = 0, bad_reads = 0, ctrl_before = -1;
    int n_writes = 0, n_beats = 0, unstable = 0;
    int exp_fc = 0, exp_dc = 0, wr0 = 0, beats0 = 0, cur_polls = 0;
    bit cur_accept = 0;

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic respond(input logic [12:0] a);
        m_axi_rresp = 2'b00;
        m_axi_rdata = 32'd0;
        if (a == 13'h17FC) begin
            ctrl_reads++;
            if (polls_left > 0) polls_left--;
            else m_axi_rdata = {31'd0, ctrl_val};
        end else if (int'(a) == 'h1000 + 4 * data_reads && data_reads < 25) begin
            if (data_reads == 0) ctrl_before = ctrl_reads;
            m_axi_rdata = mem[data_reads];
            if (data_reads == err_k) m_axi_rresp = 2'b10;
            data_reads++;
        end else begin
            bad_reads++;
            m_axi_rdata = $urandom;
        end
    endtask

    // Read slave: handshakes are decided at negedge for the following posedge.
    initial begin : rd_slave
        logic [12:0] a;
        bit ar_hs, r_hs;
        a = '0; ar_hs = 0; r_hs = 0;
        m_axi_arready = 1'b1; m_axi_rvalid = 1'b0; m_axi_rdata = '0; m_axi_rresp = '0;
        forever begin
            @(negedge aclk);
            if (!aresetn) begin
                m_axi_rvalid = 1'b0; ar_hs = 0; r_hs = 0;
            end else begin
                if (r_hs) m_axi_rvalid = 1'b0;
                if (ar_hs) begin respond(a); m_axi_rvalid = 1'b1; end
                ar_hs = m_axi_arvalid && m_axi_arready;
                if (ar_hs) a = m_axi_araddr;
                r_hs = m_axi_rvalid && m_axi_rready;
            end
        end
    end

    initial begin : wr_slave
        int aw_cnt, w_cnt;
        bit aw_done, w_done, b_hs;
        logic [12:0] wa;
        logic [31:0] wd;
        aw_cnt = 0; w_cnt = 0; aw_done = 0; w_done = 0; b_hs = 0; wa = '0; wd = '0;
        m_axi_awready = 1'b0; m_axi_wready = 1'b0; m_axi_bvalid = 1'b0; m_axi_bresp = 2'b00;
        forever begin
            @(negedge aclk);
            if (!aresetn) begin
                m_axi_awready = 1'b0; m_axi_wready = 1'b0; m_axi_bvalid = 1'b0;
                aw_cnt = 0; w_cnt = 0; aw_done = 0; w_done = 0; b_hs = 0;
            end else begin
                if (b_hs) begin m_axi_bvalid = 1'b0; b_hs = 0; end
                if (m_axi_awready) begin m_axi_awready = 1'b0; aw_done = 1; end
                if (m_axi_wready) begin m_axi_wready = 1'b0; w_done = 1; end
                if (aw_done && w_done) begin
                    aw_done = 0; w_done = 0; m_axi_bvalid = 1'b1;
                    last_waddr = wa; last_wdata = wd; n_writes++;
                    if (wa == 13'h17FC) ctrl_val = 1'b0;
                end
                if (m_axi_bvalid && m_axi_bready) b_hs = 1;
                if (m_axi_awvalid && !aw_done) begin
                    if (aw_cnt >= aw_delay) begin m_axi_awready = 1'b1; wa = m_axi_awaddr; aw_cnt = 0; end
                    else aw_cnt++;
                end
                if (m_axi_wvalid && !w_done) begin
                    if (w_cnt >= w_delay) begin m_axi_wready = 1'b1; wd = m_axi_wdata; w_cnt = 0; end
                    else w_cnt++;
                end
            end
        end
    end

    initial begin : st_mon
        logic [127:0] prev;
        bit hold;
        prev = '0; hold = 0;
        forever begin
            @(negedge aclk);
            if (hold && (!m_axis_tvalid || m_axis_tdata !== prev)) unstable++;
            hold = aresetn && m_axis_tvalid && !m_axis_tready;
            prev = m_axis_tdata;
            if (aresetn && m_axis_tvalid && m_axis_tready) begin
                n_beats++;
                check("beat_expected", 128'(sb_q.size() != 0), 128'd1);
                if (sb_q.size() != 0) check("tdata", m_axis_tdata, sb_q.pop_front());
            end
        end
    end

    task automatic check_idle(input string tag);
        check({tag, "_valids"}, 128'({m_axis_tvalid, m_axi_arvalid, m_axi_rready, m_axi_awvalid, m_axi_wvalid, m_axi_bready}), 128'd0);
        check({tag, "_addr_data"}, 128'({m_axi_araddr, m_axi_awaddr, m_axi_wdata}), 128'd0);
        check({tag, "_counts"}, 128'({frame_count, drop_count}), 128'd0);
        check({tag, "_tdata"}, m_axis_tdata, 128'd0);
        check({tag, "_wstrb"}, 128'(m_axi_wstrb), 128'hF);
    endtask

    task automatic start_frame(input bit good, input int polls, input int ek, input int awd, input int wd, input bit abort);
        logic [127:0] exp;
        exp = '0;
        for (int i = 0; i < 25; i++) mem[i] = $urandom;
        mem[3][15:0] = 16'h0008;
        mem[5][31:24] = 8'h11;
        mem[9] = good ? 32'h0000C507 : 32'h4000C508;
        for (int i = 0; i < 8; i++) begin
            exp[16*i +: 16] = {8'(2*i+1), 8'(2*i+2)};
            mem[17+i][15:0] = exp[16*i +: 16];
        end
        cur_accept = good && ek < 0 && !abort;
        if (cur_accept) begin sb_q.push_back(exp); exp_fc++; end
        else if (!abort) exp_dc++;
        err_k = ek; aw_delay = awd; w_delay = wd; cur_polls = polls; polls_left = polls;
        ctrl_reads = 0; data_reads = 0; bad_reads = 0; ctrl_before = -1;
        wr0 = n_writes; beats0 = n_beats;
        ctrl_val = 1'b1;
    endtask

    task automatic finish_frame(input string tag);
        int c;
        c = 0;
        while (n_writes <= wr0 && c < 3000) begin @(posedge aclk); c++; end
        check({tag, "_released"}, 128'(n_writes > wr0), 128'd1);
        repeat (3) @(posedge aclk);
        #1;
        check({tag, "_data_reads"}, 128'(data_reads), 128'd25);
        check({tag, "_stray_reads"}, 128'(bad_reads), 128'd0);
        check({tag, "_polls"}, 128'(ctrl_before), 128'(cur_polls + 1));
        check({tag, "_waddr"}, 128'(last_waddr), 128'h17FC);
        check({tag, "_wdata"}, 128'(last_wdata), 128'd0);
        check({tag, "_beats"}, 128'(n_beats - beats0), 128'(cur_accept));
        check({tag, "_frames"}, 128'(frame_count), 128'(exp_fc));
        check({tag, "_drops"}, 128'(drop_count), 128'(exp_dc));
    endtask

    initial begin : main
        int c;
        m_axis_tready = 1'b1;
        repeat (5) @(posedge aclk);
        #1;
        check_idle("reset");
        aresetn = 1'b1;
        start_frame(1, 0, -1, 0, 0, 0);  finish_frame("valid");
        start_frame(1, 50, -1, 0, 1, 0); finish_frame("poll50");
        start_frame(0, 3, -1, 1, 0, 0);  finish_frame("bad_port");
        start_frame(1, 0, -1, 0, 0, 0);  finish_frame("after_drop");
        start_frame(1, 1, 20, 0, 0, 0);  finish_frame("slverr");
        m_axis_tready = 1'b0;
        start_frame(1, 2, -1, 1, 1, 0);
        c = 0;
        while (!m_axis_tvalid && c < 3000) begin @(posedge aclk); #1; c++; end
        check("bp_tvalid_seen", 128'(m_axis_tvalid), 128'd1);
        c = n_writes;
        repeat (30) @(posedge aclk);
        #1;
        check("bp_tvalid_held", 128'(m_axis_tvalid), 128'd1);
        check("bp_tdata", m_axis_tdata, sb_q.size() != 0 ? sb_q[0] : 128'd0);
        check("bp_no_release", 128'(n_writes - c), 128'd0);
        check("bp_stable", 128'(unstable), 128'd0);
        m_axis_tready = 1'b1;
        finish_frame("backpressure");
        start_frame(1, 0, -1, 0, 0, 1);
        c = 0;
        while (data_reads < 10 && c < 3000) begin @(posedge aclk); c++; end
        #1;
        check("abort_reached_k10", 128'(data_reads >= 10), 128'd1);
        aresetn = 1'b0;
        ctrl_val = 1'b0; exp_fc = 0; exp_dc = 0;
        sb_q.delete();
        repeat (3) @(posedge aclk);
        #1;
        check_idle("midreset");
        aresetn = 1'b1;
        start_frame(1, 0, -1, 0, 0, 0);  finish_frame("post_reset");
        check("sb_drained", 128'(sb_q.size()), 128'd0);
        check("tdata_stable", 128'(unstable), 128'd0);
        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end
endmodule
